// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer: shift-add multiply, restoring divide.
// Ports: in_valid/in_ready/op/rs1_val/rs2_val/rd_in request side,
//        out_valid/out_ready/result/rd_out response side, kill, busy.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opnd;
    logic [7:0]      op_q;
    logic            neg_q;
    logic            neg_r;

    logic [7:0]      op_sel;
    logic            is_div;
    logic            a_sgn;
    logic            b_sgn;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;
    logic            accept;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   fix_res;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    // Isolate the lowest set bit so a multi-hot op picks the lowest one.
    assign op_sel = op & (~op + 8'd1);
    assign is_div = |op_sel[7:4];
    assign a_sgn  = op_sel[1] | op_sel[2] | op_sel[4] | op_sel[6];
    assign b_sgn  = op_sel[1] | op_sel[4] | op_sel[6];
    assign sa     = a_sgn & rs1_val[XLEN-1];
    assign sb     = b_sgn & rs2_val[XLEN-1];
    assign mag_a  = sa ? (~rs1_val + 1'b1) : rs1_val;
    assign mag_b  = sb ? (~rs2_val + 1'b1) : rs2_val;

    assign div_zero = is_div && (rs2_val == '0);
    assign div_ovf  = (op_sel[4] | op_sel[6])
                   && (rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                   && (rs2_val == {XLEN{1'b1}});
    assign accept   = in_valid && in_ready && (op != 8'd0);

    // Multiply: hi accumulates, lo holds the multiplier shifting out.
    assign mul_sum = {1'b0, hi} + {1'b0, {XLEN{lo[0]}} & opnd};
    // Divide: hi is the partial remainder, lo shifts dividend in / quotient out.
    assign div_trial = {hi, lo[XLEN-1]} - {1'b0, opnd};

    assign prod   = {hi, lo};
    assign prod_s = neg_q ? (~prod + 1'b1) : prod;

    always_comb begin
        fix_res = '0;
        unique case (1'b1)
            op_q[0]:                     fix_res = prod_s[XLEN-1:0];
            op_q[1], op_q[2], op_q[3]:   fix_res = prod_s[2*XLEN-1:XLEN];
            op_q[4], op_q[5]:            fix_res = neg_q ? (~lo + 1'b1) : lo;
            op_q[6], op_q[7]:            fix_res = neg_r ? (~hi + 1'b1) : hi;
            default:                     fix_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= op_sel;
                        rd_out <= rd_in;
                        neg_q  <= sa ^ sb;
                        neg_r  <= sa;
                        cnt    <= '0;
                        hi     <= '0;
                        if (div_zero) begin
                            result <= (op_sel[4] | op_sel[5])
                                    ? {XLEN{1'b1}} : rs1_val;
                            state  <= DONE;
                        end else if (div_ovf) begin
                            result <= op_sel[4] ? rs1_val : '0;
                            state  <= DONE;
                        end else begin
                            lo    <= is_div ? mag_a : mag_b;
                            opnd  <= is_div ? mag_b : mag_a;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        if (|op_q[3:0]) begin
                            hi <= mul_sum[XLEN:1];
                            lo <= {mul_sum[0], lo[XLEN-1:1]};
                        end else if (!div_trial[XLEN]) begin
                            hi <= div_trial[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], 1'b1};
                        end else begin
                            hi <= {hi[XLEN-2:0], lo[XLEN-1]};
                            lo <= {lo[XLEN-2:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(XLEN-1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        result <= fix_res;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (kill || out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
